// File: rtl/axi_llc_burst_sequencer.sv
// Shared payload types for the burst sequencer and its cutter.
package axi_llc_burst_sequencer_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned LenWidth  = 8;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

  // Subset of an AXI AW/AR channel seen by the cutter.
  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [LenWidth-1:0]  len;
    logic [2:0]           size;
    logic [1:0]           burst;
  } chan_t;

  // One cache-line descriptor produced by the cutter.
  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [LenWidth-1:0]  len;
    logic                 x_last;
  } desc_t;

endpackage

// axi_llc_burst_sequencer
//   Accepts one AXI Ax burst, drives the combinational burst cutter with the
//   remaining burst and emits one cache-line descriptor per handshake, feeding
//   the cutter's remaining-burst output back until the last descriptor.
// Ports:
//   clk_i, rst_ni              clock, async active-low reset
//   stall_i                    blocks new Ax acceptance only
//   ax_chan_i/valid_i/ready_o  incoming burst handshake
//   cut_chan_o                 current remaining burst to the cutter
//   cut_next_i, cut_desc_i     cutter results
//   desc_o/valid_o/ready_i     descriptor handshake
//   busy_o                     a burst is being cut
//   desc_cnt_o                 descriptors emitted for the current burst
module axi_llc_burst_sequencer #(
  parameter type chan_t = axi_llc_burst_sequencer_pkg::chan_t,
  parameter type desc_t = axi_llc_burst_sequencer_pkg::desc_t
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       stall_i,
  input  chan_t      ax_chan_i,
  input  logic       ax_valid_i,
  output logic       ax_ready_o,
  output chan_t      cut_chan_o,
  input  chan_t      cut_next_i,
  input  desc_t      cut_desc_i,
  output desc_t      desc_o,
  output logic       desc_valid_o,
  input  logic       desc_ready_i,
  output logic       busy_o,
  output logic [8:0] desc_cnt_o
);

  localparam int unsigned CntWidth = 9;
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(256);

  typedef enum logic {
    IDLE = 1'b0,
    CUT  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  chan_t               chan_q, chan_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  // State and burst registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      chan_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    state_d      = state_q;
    chan_d       = chan_q;
    cnt_d        = cnt_q;
    ax_ready_o   = 1'b0;
    desc_valid_o = 1'b0;
    busy_o       = 1'b0;
    desc_o       = cut_desc_i;

    unique case (state_q)
      IDLE: begin
        // Reset term keeps ready low while the block is held in reset.
        ax_ready_o = rst_ni && !stall_i;
        if (ax_valid_i && ax_ready_o) begin
          chan_d  = ax_chan_i;
          cnt_d   = '0;
          state_d = CUT;
        end
      end
      CUT: begin
        busy_o       = 1'b1;
        desc_valid_o = 1'b1;
        if (desc_ready_i) begin
          cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntWidth'(1);
          if (cut_desc_i.x_last) begin
            state_d = IDLE;
          end else begin
            chan_d = cut_next_i;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Cutter is combinational, so it always sees the registered remaining burst.
  assign cut_chan_o = chan_q;
  assign desc_cnt_o = cnt_q;

`ifndef SYNTHESIS
  // Descriptor must hold while stalled by downstream.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   desc_valid_o && !desc_ready_i |=> desc_valid_o && $stable(desc_o));
  // No new burst may be taken while cutting.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   state_q == CUT |-> !ax_ready_o);
`endif

endmodule

// File: tb/tb_axi_llc_burst_sequencer.sv
module tb_axi_llc_burst_sequencer;
  import axi_llc_burst_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       stall;
  chan_t      ax_chan;
  logic       ax_valid;
  logic       ax_ready;
  chan_t      cut_chan;
  chan_t      cut_next;
  desc_t      cut_desc;
  desc_t      desc;
  logic       desc_valid;
  logic       desc_ready;
  logic       busy;
  logic [8:0] desc_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int rdy_mode = 1;  // 0 random, 1 always ready, 2 never ready
  desc_t exp_q[$];

  always #5 clk = ~clk;

  axi_llc_burst_sequencer dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .stall_i      (stall),
    .ax_chan_i    (ax_chan),
    .ax_valid_i   (ax_valid),
    .ax_ready_o   (ax_ready),
    .cut_chan_o   (cut_chan),
    .cut_next_i   (cut_next),
    .cut_desc_i   (cut_desc),
    .desc_o       (desc),
    .desc_valid_o (desc_valid),
    .desc_ready_i (desc_ready),
    .busy_o       (busy),
    .desc_cnt_o   (desc_cnt)
  );

  // Behavioural 64-byte-line cutter (FIXED/INCR, size-aligned addresses).
  int unsigned cb_line, cb_rem;
  always_comb begin
    cut_next        = cut_chan;
    cut_desc        = '0;
    cut_desc.addr   = cut_chan.addr;
    cut_desc.len    = cut_chan.len;
    cut_desc.x_last = 1'b1;
    cb_line         = 0;
    cb_rem          = 0;
    if (cut_chan.burst != BurstFixed) begin
      cb_line = (32'd64 - 32'(cut_chan.addr[5:0])) >> cut_chan.size;
      cb_rem  = 32'(cut_chan.len) + 32'd1;
      if (cb_line < cb_rem) begin
        cut_desc.len    = 8'(cb_line - 1);
        cut_desc.x_last = 1'b0;
        cut_next.addr   = (cut_chan.addr & ~32'h3F) + 32'h40;
        cut_next.len    = 8'(cb_rem - cb_line - 1);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: walk every beat, close a descriptor whenever the next beat leaves the line.
  task automatic ref_push(input chan_t c, output int n);
    desc_t d;
    int unsigned bsize, beats, gs, a;
    n = 0;
    if (c.burst == BurstFixed) begin
      d.addr = c.addr; d.len = c.len; d.x_last = 1'b1;
      exp_q.push_back(d);
      n = 1;
    end else begin
      bsize = 32'd1 << c.size;
      beats = 32'(c.len) + 1;
      gs    = 0;
      for (int unsigned i = 0; i < beats; i++) begin
        a = c.addr + i * bsize;
        if (i == beats - 1 || ((a + bsize) / 64) != (a / 64)) begin
          d.addr   = c.addr + gs * bsize;
          d.len    = 8'(i - gs);
          d.x_last = (i == beats - 1);
          exp_q.push_back(d);
          n++;
          gs = i + 1;
        end
      end
    end
  endtask

  // Ready pattern generator.
  initial begin
    desc_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       desc_ready = ($urandom_range(0, 3) != 0);
        1:       desc_ready = 1'b1;
        default: desc_ready = 1'b0;
      endcase
    end
  end

  // Monitor: scoreboard pop on each descriptor handshake, plus hold-stability.
  logic  hold = 1'b0;
  desc_t hold_desc;
  always @(negedge clk) begin
    if (!rst_ni) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", 64'(desc_valid), 64'd1);
        check("hold_desc", 64'(desc), 64'(hold_desc));
      end
      if (desc_valid && desc_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_desc", 64'(desc), 64'd0);
          n_errors += (desc == '0) ? 1 : 0;
        end else begin
          check("desc", 64'(desc), 64'(exp_q.pop_front()));
        end
      end
      hold      = desc_valid && !desc_ready;
      hold_desc = desc;
    end
  end

  task automatic send_burst(input chan_t c, output int n);
    bit got = 0;
    ref_push(c, n);
    @(posedge clk); #1;
    ax_chan  = c;
    ax_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ax_ready) begin got = 1; break; end
    end
    if (!got) check("ax_accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    ax_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) begin done = 1; break; end
    end
    if (!done) check("idle_timeout", 64'd0, 64'd1);
  endtask

  function automatic chan_t mk(input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst);
    chan_t c;
    c.addr = addr; c.len = len; c.size = size; c.burst = burst;
    return c;
  endfunction

  initial begin
    int n;
    chan_t c;
    rst_ni   = 1'b0;
    stall    = 1'b0;
    ax_valid = 1'b0;
    ax_chan  = '0;
    repeat (3) @(negedge clk);
    check("rst_ax_ready", 64'(ax_ready), 64'd0);
    check("rst_desc_valid", 64'(desc_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_desc_cnt", 64'(desc_cnt), 64'd0);
    @(posedge clk); #1 rst_ni = 1'b1;

    // Directed latency: INCR 0x1020 len 7 size 3 -> 2 descriptors.
    ref_push(mk(32'h1020, 8'd7, 3'd3, BurstIncr), n);
    @(posedge clk); #1;
    ax_chan  = mk(32'h1020, 8'd7, 3'd3, BurstIncr);
    ax_valid = 1'b1;
    @(negedge clk);
    check("lat_ax_ready", 64'(ax_ready), 64'd1);
    @(posedge clk); #1 ax_valid = 1'b0;
    @(negedge clk); check("lat_n1_valid", 64'(desc_valid), 64'd1);
    @(negedge clk); check("lat_n2_valid", 64'(desc_valid), 64'd1);
    @(negedge clk); check("lat_n3_valid", 64'(desc_valid), 64'd0);
    check("lat_cnt", 64'(desc_cnt), 64'd2);
    @(negedge clk); check("lat_n4_ax_ready", 64'(ax_ready), 64'd1);

    // Long INCR, 32 lines.
    send_burst(mk(32'h0, 8'd255, 3'd3, BurstIncr), n);
    wait_idle();
    check("cnt_len255", 64'(desc_cnt), 64'(n));

    // FIXED: single descriptor.
    send_burst(mk(32'h1038, 8'd15, 3'd3, BurstFixed), n);
    wait_idle();
    check("cnt_fixed", 64'(desc_cnt), 64'd1);

    // 256 lines: count boundary.
    send_burst(mk(32'h0, 8'd255, 3'd6, BurstIncr), n);
    wait_idle();
    check("cnt_256", 64'(desc_cnt), 64'd256);

    // Stall blocks acceptance only.
    @(posedge clk); #1;
    stall    = 1'b1;
    c        = mk(32'h2000, 8'd63, 3'd3, BurstIncr);
    ax_chan  = c;
    ax_valid = 1'b1;
    ref_push(c, n);
    repeat (3) begin
      @(negedge clk); check("stall_ax_ready", 64'(ax_ready), 64'd0);
    end
    @(posedge clk); #1 stall = 1'b0;
    @(negedge clk); check("unstall_ax_ready", 64'(ax_ready), 64'd1);
    @(posedge clk); #1 ax_valid = 1'b0;
    stall = 1'b1;  // in-flight burst must proceed regardless
    repeat (3) @(negedge clk);
    check("stall_cut_busy", 64'(busy), 64'd1);
    // Downstream stall for 5 cycles mid-burst.
    rdy_mode = 2;
    repeat (5) @(posedge clk);
    rdy_mode = 1;
    wait_idle();
    stall = 1'b0;
    check("cnt_stall", 64'(desc_cnt), 64'(n));

    // Reset after first of 4 descriptors.
    send_burst(mk(32'h0, 8'd31, 3'd3, BurstIncr), n);
    @(posedge clk); #1 rst_ni = 1'b0;
    #1;
    check("midrst_valid", 64'(desc_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_cnt", 64'(desc_cnt), 64'd0);
    exp_q.delete();
    @(posedge clk); #1 rst_ni = 1'b1;
    send_burst(mk(32'h3010, 8'd11, 3'd2, BurstIncr), n);
    wait_idle();
    check("cnt_after_rst", 64'(desc_cnt), 64'(n));

    // Randomized bursts with random downstream ready.
    rdy_mode = 0;
    for (int k = 0; k < 40; k++) begin
      logic [2:0]  sz;
      logic [31:0] addr;
      sz   = 3'($urandom_range(0, 3));
      addr = ($urandom & 32'hFFFF) & ~((32'd1 << sz) - 1);
      c    = mk(addr, 8'($urandom_range(0, 40)), sz,
                ($urandom_range(0, 3) == 0) ? BurstFixed : BurstIncr);
      send_burst(c, n);
      wait_idle();
      check("cnt_rand", 64'(desc_cnt), 64'(n));
    end

    rdy_mode = 1;
    repeat (2) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
